// File: rtl/serial_mul_pkg.sv
// serial_mul_pkg: shared types and helpers for the serial multiplier front end.
//   feeder_state_t     : serial_operand_feeder FSM states
//   DATA_WIDTH_DEFAULT : default operand width
//   frame_len()        : valid cycles per frame (operand bits + flush bits)
package serial_mul_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} feeder_state_t;

  localparam int DATA_WIDTH_DEFAULT = 8;

  function automatic int frame_len(input int dw, input int flush);
    return dw + flush;
  endfunction
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shift register, LSB first.
//   i_clk   clock
//   i_rst   synchronous active-high reset, clears the register
//   i_load  parallel load of i_data (wins over i_shift)
//   i_shift shift right by one, zero shifted in at the MSB
//   i_data  parallel load value
//   o_bit   current LSB
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);
  logic [WIDTH-1:0] sr;

  always_ff @(posedge i_clk) begin
    if (i_rst)        sr <= '0;
    else if (i_load)  sr <= i_data;
    else if (i_shift) sr <= {1'b0, sr[WIDTH-1:1]};
  end

  assign o_bit = sr[0];
endmodule

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: accepts one (A, B) pair per frame over valid/ready
// and streams both LSB-first, one bit per cycle, followed by FLUSH_CYCLES
// zero bits so a downstream serial multiplier drains.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid/o_ready     operand handshake; i_a, i_b operands
//   i_hold              downstream stall, freezes the frame
//   o_valid, o_a, o_b   serial bit stream
//   o_first, o_last     first / final valid cycle of a frame
// Build option: SERIAL_FEEDER_BACK2BACK_EN lets the next pair be accepted in
// the o_last cycle so frames stream with no idle gap.
module serial_operand_feeder
  import serial_mul_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int FLUSH_CYCLES = DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_hold,
  output logic                  o_valid,
  output logic                  o_a,
  output logic                  o_b,
  output logic                  o_first,
  output logic                  o_last
);
  localparam int LEN = frame_len(DATA_WIDTH, FLUSH_CYCLES);
  localparam int CW  = $clog2(LEN + 1);

  feeder_state_t state;
  logic [CW-1:0] cnt;   // bit index within the frame, 0..LEN-1
  logic          step;  // a frame bit is presented and consumed this cycle
  logic          accept;
  logic          at_data_end;
  logic          at_frame_end;

  assign step         = (state != IDLE) & ~i_hold;
  assign at_data_end  = (cnt == CW'(DATA_WIDTH - 1));
  assign at_frame_end = (cnt == CW'(LEN - 1));

  assign o_valid = step;
  assign o_first = step & (state == SHIFT) & (cnt == '0);
  assign o_last  = step & at_frame_end;

`ifdef SERIAL_FEEDER_BACK2BACK_EN
  assign o_ready = (state == IDLE) | o_last;
`else
  assign o_ready = (state == IDLE);
`endif

  assign accept = i_valid & o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      cnt   <= '0;
    end else if (step) begin
      case (state)
        SHIFT: begin
          if (at_data_end) begin
            if (FLUSH_CYCLES == 0) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              state <= FLUSH;
              cnt   <= cnt + CW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FLUSH: begin
          if (at_frame_end) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // After DATA_WIDTH shifts both registers hold zero, so flush bits come
  // out as zeros without any output muxing.
  piso_shift_reg #(.WIDTH(DATA_WIDTH)) u_sr_a (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (accept),
    .i_shift(step),
    .i_data (i_a),
    .o_bit  (o_a)
  );

  piso_shift_reg #(.WIDTH(DATA_WIDTH)) u_sr_b (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (accept),
    .i_shift(step),
    .i_data (i_b),
    .o_bit  (o_b)
  );
endmodule

// File: tb/tb_serial_operand_feeder.sv
module tb_serial_operand_feeder;
  localparam int DW  = 8;
  localparam int FL  = 8;
  localparam int LEN = DW + FL;
`ifdef SERIAL_FEEDER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk;
  logic          rst, vin, hold;
  logic [DW-1:0] ain, bin;
  logic          ready, ov, oa, ob, ofirst, olast;

  logic          rst4, v4;
  logic [3:0]    a4, b4;
  logic          ready4, ov4, oa4, ob4, of4, ol4;

  serial_operand_feeder #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FL)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(ready),
    .i_a(ain), .i_b(bin), .i_hold(hold),
    .o_valid(ov), .o_a(oa), .o_b(ob), .o_first(ofirst), .o_last(olast)
  );

  serial_operand_feeder #(.DATA_WIDTH(4), .FLUSH_CYCLES(0)) dut4 (
    .i_clk(clk), .i_rst(rst4), .i_valid(v4), .o_ready(ready4),
    .i_a(a4), .i_b(b4), .i_hold(1'b0),
    .o_valid(ov4), .o_a(oa4), .o_b(ob4), .o_first(of4), .o_last(ol4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: every accepted pair becomes LEN expected bit entries.
  typedef struct {
    logic a, b, f, l;
  } bit_t;
  bit_t          q[$];
  int unsigned   pq[$];
  int            checks = 0;
  int            passes = 0;
  int            frames = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic push_frame(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit_t e;
    for (int i = 0; i < LEN; i++) begin
      e.a = (i < DW) ? a[i] : 1'b0;
      e.b = (i < DW) ? b[i] : 1'b0;
      e.f = (i == 0);
      e.l = (i == LEN - 1);
      q.push_back(e);
    end
    pq.push_back(int'(a) * int'(b));
    frames++;
  endtask

  // Driver: inputs change at negedge; the handshake is judged 2 time units
  // later, after the monitor has looked at this cycle.
  task automatic cycle(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic h, input logic r);
    @(negedge clk);
    vin = v; ain = a; bin = b; hold = h; rst = r;
    #2;
    if (r) begin
      q.delete();
      pq.delete();
    end else if (v && ready) begin
      push_frame(a, b);
    end
  endtask

  // Monitor: pops one expected bit per DUT valid cycle.
  initial begin : monitor
    logic [DW-1:0] ra, rb;
    int            idx;
    logic          exp_r;
    bit_t          e;
    ra = '0; rb = '0; idx = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        exp_r = (q.size() == 0) || (B2B && q.size() == 1 && !hold);
        chk("o_valid", 32'(ov), 32'(q.size() > 0 && !hold));
        chk("o_ready", 32'(ready), 32'(exp_r));
        if (q.size() > 0) begin
          e = q[0];
          chk("o_a", 32'(oa), 32'(e.a));
          chk("o_b", 32'(ob), 32'(e.b));
          if (ov) begin
            chk("o_first", 32'(ofirst), 32'(e.f));
            chk("o_last", 32'(olast), 32'(e.l));
            if (e.f) begin ra = '0; rb = '0; idx = 0; end
            if (idx < DW) begin ra[idx] = oa; rb[idx] = ob; end
            idx++;
            if (e.l && pq.size() > 0)
              chk("product", int'(ra) * int'(rb), pq.pop_front());
            void'(q.pop_front());
          end
        end else begin
          chk("idle_first", 32'(ofirst), 32'd0);
          chk("idle_last", 32'(olast), 32'd0);
        end
      end
    end
  end

  initial begin : main
    logic [3:0] exp4;
    int         guard;
    vin = 0; ain = '0; bin = '0; hold = 0; rst = 1;
    rst4 = 1; v4 = 0; a4 = '0; b4 = '0;

    cycle(0, '0, '0, 0, 1);
    mon_en = 1'b1;
    cycle(0, '0, '0, 0, 1);
    cycle(0, '0, '0, 0, 0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_a", 32'(oa), 32'd0);
    chk("rst_b", 32'(ob), 32'd0);

    // basic frame
    cycle(1, 8'hB5, 8'h3C, 0, 0);
    for (int c = 1; c <= 20; c++) cycle(0, '0, '0, 0, 0);

    // hold in cycles 4-5 of the frame
    cycle(1, 8'hB5, 8'h3C, 0, 0);
    for (int c = 1; c <= 22; c++) cycle(0, '0, '0, (c == 4 || c == 5), 0);

    // back-to-back with valid held high
    for (int c = 0; c < 40; c++) cycle(1, DW'($urandom), DW'($urandom), 0, 0);
    for (int c = 0; c < 20; c++) cycle(0, '0, '0, 0, 0);

    // offers while busy must be ignored
    cycle(1, 8'h5A, 8'hC3, 0, 0);
    for (int c = 1; c <= 15; c++) cycle(c >= 2, 8'hFF, 8'hFF, 0, 0);
    for (int c = 0; c < 6; c++) cycle(0, '0, '0, 0, 0);

    // reset mid-frame, then a fresh frame
    cycle(1, 8'h81, 8'h7E, 0, 0);
    for (int c = 1; c <= 4; c++) cycle(0, '0, '0, 0, 0);
    cycle(0, '0, '0, 0, 1);
    cycle(0, '0, '0, 0, 0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_valid", 32'(ov), 32'd0);
    cycle(1, 8'h0F, 8'hF0, 0, 0);
    for (int c = 0; c < 18; c++) cycle(0, '0, '0, 0, 0);

    // random traffic
    frames = 0;
    guard = 0;
    while (frames < 200 && guard < 20000) begin
      cycle(($urandom_range(0, 9) < 7), DW'($urandom), DW'($urandom),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 299) == 0));
      guard++;
    end
    chk("random_frames", 32'(frames >= 200), 32'd1);

    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      cycle(0, '0, '0, 0, 0);
      guard++;
    end
    cycle(0, '0, '0, 0, 0);
    chk("drain_empty", 32'(q.size()), 32'd0);

    // narrow build, no flush cycles
    @(negedge clk);
    rst4 = 0; v4 = 1; a4 = 4'h9; b4 = 4'h6;
    #1;
    chk("w4_ready", 32'(ready4), 32'd1);
    exp4 = 4'h9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v4 = 0;
      #1;
      chk("w4_valid", 32'(ov4), 32'd1);
      chk("w4_a", 32'(oa4), 32'(exp4[i]));
      chk("w4_first", 32'(of4), 32'(i == 0));
      chk("w4_last", 32'(ol4), 32'(i == 3));
    end
    @(negedge clk);
    #1;
    chk("w4_idle_valid", 32'(ov4), 32'd0);
    chk("w4_idle_ready", 32'(ready4), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
